// File: rtl/delay_ctrl_pkg.sv
// Shared definitions for the delay_tap_ctrl delay-line controller:
// FSM state encodings, the default delay and an address-width helper.
package delay_ctrl_pkg;

    localparam logic [1:0] ST_FILL = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_CFG  = 2'd2;

    localparam int DEFAULT_DELAY_VAL = 30;

    function automatic int addr_w(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/delay_ptr_gen.sv
// Write pointer, read-address generation (wptr - delay) and the saturating
// count of valid history samples for the delay line.
module delay_ptr_gen
    import delay_ctrl_pkg::*;
#(
    parameter int DEPTH = 128,
    parameter int AW    = addr_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          advance,
    input  logic          flush,
    input  logic [AW-1:0] delay,
    output logic [AW-1:0] wptr,
    output logic [AW-1:0] raddr,
    output logic [AW-1:0] hist_cnt,
    output logic [AW-1:0] hist_next
);

    localparam logic [AW-1:0] HIST_MAX = AW'(DEPTH - 1);

    logic [AW-1:0] wptr_r;
    logic [AW-1:0] hist_r;
    logic [AW-1:0] hist_next_s;

    // Flush wins over the increment of a sample arriving in the same cycle.
    always_comb begin
        hist_next_s = hist_r;
        if (flush) begin
            hist_next_s = AW'(0);
        end else if (advance && (hist_r != HIST_MAX)) begin
            hist_next_s = hist_r + AW'(1);
        end else begin
            hist_next_s = hist_r;
        end
    end

    // Pointer and history registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_r <= AW'(0);
            hist_r <= AW'(0);
        end else begin
            if (advance) begin
                wptr_r <= wptr_r + AW'(1);
            end else begin
                wptr_r <= wptr_r;
            end
            hist_r <= hist_next_s;
        end
    end

    // Modulo-DEPTH subtraction falls out of the AW-bit wrap.
    assign raddr     = wptr_r - delay;
    assign wptr      = wptr_r;
    assign hist_cnt  = hist_r;
    assign hist_next = hist_next_s;

endmodule

// File: rtl/delay_tap_ctrl.sv
// Runtime-programmable delay line controller over a 1-cycle-latency RAM.
// Optional macro DELAY_TAP_CTRL_MUTE_EN forces out_data to 0 while unprimed.
module delay_tap_ctrl
    import delay_ctrl_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int DEPTH         = 128,
    parameter int AW            = addr_w(DEPTH),
    parameter int DEFAULT_DELAY = DEFAULT_DELAY_VAL
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [AW-1:0]     cfg_delay,
    input  logic              cfg_flush,
    output logic              mem_we,
    output logic [AW-1:0]     mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_re,
    output logic [AW-1:0]     mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_primed,
    output logic [AW-1:0]     delay_cur
);

    logic [1:0]    state_r;
    logic [1:0]    state_next_s;
    logic [AW-1:0] delay_r;
    logic [AW-1:0] cfg_delay_clamped_s;
    logic [AW-1:0] wptr_s;
    logic [AW-1:0] raddr_s;
    logic [AW-1:0] hist_s;
    logic [AW-1:0] hist_next_s;
    logic          cfg_accept_s;
    logic          sample_s;
    logic          out_valid_r;
    logic          out_primed_r;

    assign cfg_ready           = ~rst & (state_r != ST_CFG);
    assign cfg_accept_s        = cfg_valid & cfg_ready;
    assign sample_s            = in_valid & ~rst;
    assign cfg_delay_clamped_s = (cfg_delay == AW'(0)) ? AW'(1) : cfg_delay;

    delay_ptr_gen #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ptr (
        .clk       (clk),
        .rst       (rst),
        .advance   (sample_s),
        .flush     (cfg_accept_s & cfg_flush),
        .delay     (delay_r),
        .wptr      (wptr_s),
        .raddr     (raddr_s),
        .hist_cnt  (hist_s),
        .hist_next (hist_next_s)
    );

    // Next state: CFG holds one cycle, then FILL/RUN follows the updated history.
    always_comb begin
        state_next_s = state_r;
        if (cfg_accept_s) begin
            state_next_s = ST_CFG;
        end else begin
            case (state_r)
                ST_FILL, ST_RUN, ST_CFG: state_next_s = (hist_next_s >= delay_r) ? ST_RUN : ST_FILL;
                default:                 state_next_s = ST_FILL;
            endcase
        end
    end

    // State, active delay and output-stage registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_FILL;
            delay_r      <= AW'(DEFAULT_DELAY);
            out_valid_r  <= 1'b0;
            out_primed_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (cfg_accept_s) begin
                delay_r <= cfg_delay_clamped_s;
            end else begin
                delay_r <= delay_r;
            end
            out_valid_r  <= in_valid;
            out_primed_r <= in_valid & (hist_s >= delay_r);
        end
    end

    // RAM port drive; the sample in a cfg-accept cycle still uses the old delay.
    always_comb begin
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_waddr = AW'(0);
        mem_raddr = AW'(0);
        mem_wdata = in_data;
        if (rst) begin
            mem_we    = 1'b0;
            mem_re    = 1'b0;
            mem_waddr = AW'(0);
            mem_raddr = AW'(0);
        end else begin
            mem_we    = in_valid;
            mem_re    = in_valid;
            mem_waddr = wptr_s;
            mem_raddr = raddr_s;
        end
    end

    // Output data qualification.
    always_comb begin
        out_data = {DATA_W{1'b0}};
`ifdef DELAY_TAP_CTRL_MUTE_EN
        if (out_primed_r) begin
            out_data = mem_rdata;
        end else begin
            out_data = {DATA_W{1'b0}};
        end
`else
        if (out_valid_r) begin
            out_data = mem_rdata;
        end else begin
            out_data = {DATA_W{1'b0}};
        end
`endif
    end

    assign out_valid  = out_valid_r;
    assign out_primed = out_primed_r;
    assign delay_cur  = delay_r;

endmodule
